// File: rtl/seg_scan.sv
// Time-multiplexed multi-digit 7-segment driver: shadow-latched hex word, one digit per
// CLK_DIV-cycle slot, with an optional dark guard at the start of every slot.
module seg_scan #(
   parameter int DIGITS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter int BLANK_CYCLES   = 1,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1,
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  en,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic [IW-1:0]         digit_idx,
   output logic                  frame_done
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]     DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
   // XOR masks: an all-zero active-high pattern becomes the "off" level of each bus.
   localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [4*DIGITS-1:0] sh_val;
   logic [DIGITS-1:0]   sh_dp;
   logic [DIGITS-1:0]   sh_blank;
   logic [CW-1:0]       div_cnt;

   logic                wrap;
   logic                dark;
   logic [3:0]          nibble;
   logic [7:0]          seg_hi;
   logic [DIGITS-1:0]   an_hi;

   function automatic logic [7:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 8'hFC;
         4'h1: decode = 8'h60;
         4'h2: decode = 8'hDA;
         4'h3: decode = 8'hF2;
         4'h4: decode = 8'h66;
         4'h5: decode = 8'hB6;
         4'h6: decode = 8'hBE;
         4'h7: decode = 8'hE0;
         4'h8: decode = 8'hFE;
         4'h9: decode = 8'hF6;
         4'hA: decode = 8'hEE;
         4'hB: decode = 8'h3E;
         4'hC: decode = 8'h9C;
         4'hD: decode = 8'h7A;
         4'hE: decode = 8'h9E;
         default: decode = 8'h8E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_val   <= '0;
         sh_dp    <= '0;
         sh_blank <= '1;
      end else if (load) begin
         sh_val   <= value;
         sh_dp    <= dp_in;
         sh_blank <= blank_in;
      end
   end

   assign wrap = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else if (!en) begin
         div_cnt    <= '0;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap && (digit_idx == IDX_LAST);
         if (wrap) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
         end else begin
            div_cnt   <= div_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      nibble = sh_val[{digit_idx, 2'b00} +: 4];
      dark   = !en || sh_blank[digit_idx] ||
               ((BLANK_CYCLES > 0) && (32'(div_cnt) < BLANK_CYCLES));
      seg_hi = '0;
      an_hi  = '0;
      if (!dark) begin
         seg_hi           = decode(nibble) | {7'b0, sh_dp[digit_idx]};
         an_hi[digit_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= seg_hi ^ SEG_OFF;
         an  <= an_hi ^ AN_OFF;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: slot-position arithmetic model checked every cycle, plus literal
// expectations for the directed display scenarios.
module tb_seg_scan;

   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 4;
   localparam int BLANK   = 1;
   localparam int FRAME   = CLK_DIV * DIGITS;

   logic                clk;
   logic                rst_n;
   logic                load;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp_in;
   logic [DIGITS-1:0]   blank_in;
   logic                en;
   logic [7:0]          seg;
   logic [DIGITS-1:0]   an;
   logic [1:0]          digit_idx;
   logic                frame_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] dec_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   seg_scan #(
      .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK),
      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
      .blank_in(blank_in), .en(en), .seg(seg), .an(an), .digit_idx(digit_idx),
      .frame_done(frame_done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The model tracks only how many consecutive enabled cycles have elapsed (m_n);
   // slot and phase are derived from it arithmetically.
   int                  m_n;
   logic                m_valid = 1'b0;
   logic [4*DIGITS-1:0] m_val;
   logic [DIGITS-1:0]   m_dp;
   logic [DIGITS-1:0]   m_blank;
   logic [7:0]          e_seg;
   logic [DIGITS-1:0]   e_an;
   logic [1:0]          e_idx;
   logic                e_fd;

   always @(negedge clk) begin
      int slot;
      int phase;
      logic [3:0] nib;
      if (!rst_n) begin
         m_n = 0; m_val = '0; m_dp = '0; m_blank = '1;
         e_seg = 8'h00; e_an = '1; e_idx = 0; e_fd = 0;
         m_valid = 1'b1;
      end
      if (m_valid) begin
         chk("seg", 32'(seg), 32'(e_seg));
         chk("an", 32'(an), 32'(e_an));
         chk("digit_idx", 32'(digit_idx), 32'(e_idx));
         chk("frame_done", 32'(frame_done), 32'(e_fd));
      end
      if (rst_n && m_valid) begin
         if (en) begin
            slot  = (m_n / CLK_DIV) % DIGITS;
            phase = m_n % CLK_DIV;
            if (phase < BLANK || m_blank[slot]) begin
               e_seg = 8'h00; e_an = '1;
            end else begin
               nib   = m_val[slot*4 +: 4];
               e_seg = dec_tab[nib] | {7'b0, m_dp[slot]};
               e_an  = ~(DIGITS'(1) << slot);
            end
            m_n   = m_n + 1;
            e_idx = 2'((m_n / CLK_DIV) % DIGITS);
            e_fd  = (m_n % FRAME) == 0;
         end else begin
            e_seg = 8'h00; e_an = '1; m_n = 0; e_idx = 0; e_fd = 0;
         end
         if (load) begin
            m_val = value; m_dp = dp_in; m_blank = blank_in;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Leaves the bench 2 time units after the edge that captured the load with div_cnt = 0.
   task automatic restart(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
      en = 1'b0; load = 1'b0;
      step();
      value = v; dp_in = dp; blank_in = bl; load = 1'b1; en = 1'b1;
      step();
      load = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] lit_seg [4];
      logic [3:0] lit_an  [4];
      int fd_count;
      int lit_count;

      lit_seg = '{8'hFC, 8'hE0, 8'hEF, 8'hF2};
      lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

      rst_n = 1'b0; load = 1'b0; en = 1'b0;
      value = '0; dp_in = '0; blank_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_seg", 32'(seg), 32'h00);
      chk("reset_an", 32'(an), 32'hF);
      chk("reset_idx", 32'(digit_idx), 0);
      chk("reset_fd", 32'(frame_done), 0);
      #1 rst_n = 1'b1;

      // Enabled without any load: shadow blank keeps everything dark.
      en = 1'b1;
      fd_count = 0; lit_count = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (frame_done) fd_count++;
         if (seg != 8'h00 || an != 4'hF) lit_count++;
      end
      chk("noload_fd_pulses", 32'(fd_count), 2);
      chk("noload_lit_cycles", 32'(lit_count), 0);

      // One full frame of 16'h3A70 with dp on digit 2.
      restart(16'h3A70, 4'b0100, 4'b0000);
      for (int k = 0; k < FRAME; k++) begin
         if (k % CLK_DIV == 0) begin
            chk("frame_seg_dark", 32'(seg), 32'h00);
            chk("frame_an_dark", 32'(an), 32'hF);
         end else begin
            chk("frame_seg", 32'(seg), 32'(lit_seg[k / CLK_DIV]));
            chk("frame_an", 32'(an), 32'(lit_an[k / CLK_DIV]));
         end
         step();
      end

      // Every nibble through digit 0.
      for (int n = 0; n < 16; n++) begin
         restart(16'(n), 4'b0000, 4'b1110);
         step();
         chk("sweep_seg", 32'(seg), 32'(dec_tab[n]));
         chk("sweep_an", 32'(an), 32'hE);
      end

      // Digits 1 and 3 blanked.
      restart(16'h3A70, 4'b0000, 4'b1010);
      for (int k = 0; k < FRAME; k++) begin
         if ((k / CLK_DIV) % 2 == 1 || k % CLK_DIV == 0)
            chk("blank_an_dark", 32'(an), 32'hF);
         else
            chk("blank_an_lit", 32'(an), 32'(lit_an[k / CLK_DIV]));
         step();
      end

      // Drop en mid-slot at digit 2, then resume.
      restart(16'h3A70, 4'b0000, 4'b0000);
      repeat (9) step();
      chk("pre_off_idx", 32'(digit_idx), 2);
      en = 1'b0;
      step();
      chk("off_seg", 32'(seg), 32'h00);
      chk("off_an", 32'(an), 32'hF);
      chk("off_idx", 32'(digit_idx), 0);
      en = 1'b1;
      step();
      chk("resume_dark_an", 32'(an), 32'hF);
      step();
      chk("resume_seg", 32'(seg), 32'hFC);
      chk("resume_an", 32'(an), 32'hE);

      // Asynchronous reset mid-frame.
      repeat (5) step();
      #1 rst_n = 1'b0;
      #1;
      chk("areset_seg", 32'(seg), 32'h00);
      chk("areset_an", 32'(an), 32'hF);
      chk("areset_idx", 32'(digit_idx), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      lit_count = 0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         if (an != 4'hF) lit_count++;
      end
      chk("areset_stays_dark", 32'(lit_count), 0);

      // Randomised traffic against the model.
      for (int k = 0; k < 800; k++) begin
         en       = ($urandom_range(0, 24) != 0);
         load     = ($urandom_range(0, 6) == 0);
         value    = 16'($urandom());
         dp_in    = 4'($urandom());
         blank_in = 4'($urandom()) & 4'($urandom());
         step();
      end
      load = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Parametrised, time-multiplexed multi-digit 7-segment display driver.
- Latches a packed hex word and per-digit decimal-point and blank masks.
- Scans one digit per slot, decodes the digit's nibble to segments, and drives shared segment lines plus per-digit anode enables.
- Sits between control logic (counters, keyboard or PS/2 decode) and the board's segment/anode pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES).
- BLANK_CYCLES, 1, cycles at the start of each slot with all anodes inactive (anti-ghosting; 0 disables).
- SEG_ACTIVE_LOW, 0, 1 inverts the seg output.
- AN_ACTIVE_LOW, 1, 1 makes an active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  capture value/dp_in/blank_in into shadow registers.
- value  in  4*DIGITS  packed nibbles; digit k = value[4k+3:4k].
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  DIGITS  1 = digit dark.
- en  in  1  scan enable.
- seg  out  8  {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp.
- an  out  DIGITS  digit enables.
- digit_idx  out  max(1,$clog2(DIGITS))  digit currently being scanned.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Everything is in one clock domain. Reset is asynchronous and active-low, and all registers reset on it.
- Reset values:
  - shadow value = 0, shadow dp = 0, shadow blank = all 1s.
  - div_cnt = 0, digit_idx = 0, frame_done = 0.
  - seg = all segments off and an = all inactive, both after polarity is applied.
- Shadow capture:
  - When load is 1 at an edge, all three shadow registers update at that edge.
  - load is honoured regardless of en.
  - Display uses only shadow state; value, dp_in and blank_in are ignored while load = 0.
- Scan counter (when en = 1):
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - On wrap, digit_idx increments; DIGITS-1 wraps to 0.
  - frame_done = 1 for exactly the one cycle after the wrap from idx DIGITS-1 to 0. It is registered and high together with the first cycle of idx 0.
- en = 0:
  - div_cnt and digit_idx clear to 0 synchronously.
  - frame_done = 0.
  - Outputs go dark on the next cycle.
  - Scanning restarts from digit 0, count 0, when en returns to 1.
- Output registers: seg and an at cycle t+1 are a function of (en, div_cnt, digit_idx, shadow) at cycle t, so the latency is 1 cycle.
  - Dark (seg off, an inactive) if en = 0, or div_cnt < BLANK_CYCLES, or shadow blank[idx] = 1.
  - Otherwise an has only bit idx active, and seg = decode(nibble[idx]) with bit0 = shadow dp[idx].
- Decode table, active-high, before inversion, dp = 0:
  - 0:FC, 1:60, 2:DA, 3:F2, 4:66, 5:B6, 6:BE, 7:E0
  - 8:FE, 9:F6, A:EE, b:3E, C:9C, d:7A, E:9E, F:8E
- Polarity is applied last: seg inverted if SEG_ACTIVE_LOW; an inverted if AN_ACTIVE_LOW.
- load on the same edge as a slot change: the new digit uses the new shadow data.
- DIGITS = 1: digit_idx stays 0, and frame_done pulses every CLK_DIV cycles.

Test Plan:
- Bench parameters for all scenarios: DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1.
- Reset then en=1, no load -> seg=00 and an=1111 for 40 cycles; digit_idx cycles 0,1,2,3 every 4 cycles; frame_done pulses every 16 cycles.
- load value=16'h3A70, dp_in=4'b0100, blank_in=0, en=1 -> per slot: 1 cycle dark, then 3 cycles of:
  - idx0: seg=FC, an=1110
  - idx1: seg=E0, an=1101
  - idx2: seg=EF, an=1011
  - idx3: seg=F2, an=0111
- Sweep nibbles 0..F through digit 0, one load each -> seg matches the decode table entry for every nibble.
- blank_in=4'b1010 -> digits 1 and 3 stay dark (an=1111) for their whole slots; digits 0 and 2 light normally.
- Deassert en mid-slot at idx 2 -> next cycle seg=00, an=1111, digit_idx=0; after re-enable, idx0 is dark for 1 cycle, then lit.
- Assert rst_n=0 mid-frame asynchronously -> outputs dark, shadow blank all 1s; display stays dark until a new load.
